// File: rtl/button_debouncer_pkg.sv
// Package for the button debouncer slice.
// Holds the FSM state encoding and the default qualification length.
// These are shared by the debouncer top and any other block that inspects its state.
package button_debouncer_pkg;

    // Two-state qualification FSM: IDLE means level agrees with the input;
    // WAIT means a candidate change is being counted.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    // Default number of consecutive differing samples needed to flip level.
    localparam int STABLE_CYCLES_DEFAULT = 16;

endpackage

// File: rtl/button_debouncer_sync_2ff.sv
// sync_2ff: two-flop synchronizer for a single asynchronous input.
// Reusable by any asynchronous input in the codebase.
// Ports:
//   clk   - sampling clock (rising edge)
//   rst_n - asynchronous active-low reset; both flops clear to 0
//   d     - raw asynchronous input
//   q     - synchronized output, two clock edges behind d
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic s1;

    // s1 may go metastable; only s2 (q) is ever consumed downstream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            q  <= 1'b0;
        end else begin
            s1 <= d;
            q  <= s1;
        end
    end

endmodule

// File: rtl/button_debouncer.sv
// button_debouncer: turns a bouncy asynchronous input into a clean debounced
// level plus single-cycle rise/fall pulses.
// The input is synchronized first. Then a counter requires STABLE_CYCLES consecutive
// samples that differ from the current level before the level flips.
// Ports:
//   clk   - single clock, rising edge
//   rst_n - asynchronous active-low reset; clears all state and outputs
//   din   - raw asynchronous input (may glitch at any time)
//   level - debounced level (registered)
//   rise  - one-cycle pulse on a debounced 0->1 change (registered)
//   fall  - one-cycle pulse on a debounced 1->0 change (registered)
//   busy  - high while a candidate change is being qualified (registered)
module button_debouncer
    import button_debouncer_pkg::*;
#(
    parameter int STABLE_CYCLES = STABLE_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall,
    output logic busy
);

    localparam int CNT_W = $clog2(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             s2;
    logic             diff;
    state_t           state;
    logic [CNT_W-1:0] cnt;

    sync_2ff u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (din),
        .q     (s2)
    );

    assign diff = (s2 != level);

    // Qualification FSM. All outputs are registered here, so din has no
    // combinational path to any output. Pulses default low every edge and are
    // only raised on the flip edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
            busy  <= 1'b0;
        end else begin
            rise <= 1'b0;
            fall <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (diff) begin
                        state <= ST_WAIT;
                        cnt   <= CNT_ONE;
                        busy  <= 1'b1;
                    end else begin
                        cnt   <= '0;
                    end
                end
                ST_WAIT: begin
                    if (!diff) begin
                        // Glitch rejected: a single agreeing sample restarts qualification.
                        state <= ST_IDLE;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end else if (cnt == CNT_MAX) begin
                        // The sample at this edge is the STABLE_CYCLES-th differing one.
                        level <= s2;
                        rise  <= s2;
                        fall  <= ~s2;
                        state <= ST_IDLE;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end else begin
                        cnt   <= cnt + CNT_ONE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    cnt   <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_button_debouncer.sv
// Testbench for button_debouncer with STABLE_CYCLES=4.
// The stimulus process drives din one cycle at a time. It advances a reference model:
// a two-sample delay queue for the synchronizer, plus a run length of samples that
// differ from the level. It pushes the expected {level,rise,fall,busy} for every edge.
// The monitor pops one entry per edge and compares it with the DUT outputs.
module tb_button_debouncer;

    localparam int N = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic din   = 1'b0;
    logic level, rise, fall, busy;

    always #5 clk = ~clk;

    button_debouncer #(.STABLE_CYCLES(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (din),
        .level (level),
        .rise  (rise),
        .fall  (fall),
        .busy  (busy)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [3:0] expq[$];
    bit         syncq[$];
    bit         m_lvl;
    int         m_run;

    int edge_no        = 0;
    int rise_cnt       = 0;
    int fall_cnt       = 0;
    int last_rise_edge = -1;
    int last_fall_edge = -1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at time %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        syncq.delete();
        syncq.push_back(1'b0);
        syncq.push_back(1'b0);
        m_lvl = 1'b0;
        m_run = 0;
        expq.delete();
    endtask

    // One clock of stimulus. The FSM at this edge sees din from two edges ago.
    // The level flips once N consecutive samples disagree with it.
    task automatic cycle(input bit d);
        bit s;
        bit r;
        bit f;
        @(negedge clk);
        din = d;
        s = syncq.pop_front();
        syncq.push_back(d);
        r = 1'b0;
        f = 1'b0;
        if (s != m_lvl) begin
            m_run++;
            if (m_run == N) begin
                m_lvl = s;
                r     = s;
                f     = !s;
                m_run = 0;
            end
        end else begin
            m_run = 0;
        end
        expq.push_back({m_lvl, r, f, (m_run > 0)});
    endtask

    // Let the monitor process the last pushed edge.
    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    // Monitor: one pop/compare per clock edge, sampled 1 time unit after it.
    initial begin
        logic [3:0] e;
        forever begin
            @(posedge clk);
            #1;
            edge_no++;
            if (rise) begin
                rise_cnt++;
                last_rise_edge = edge_no;
            end
            if (fall) begin
                fall_cnt++;
                last_fall_edge = edge_no;
            end
            if (expq.size() > 0) begin
                e = expq.pop_front();
                check("outputs{level,rise,fall,busy}", 32'({level, rise, fall, busy}), 32'(e));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int r0;
        int f0;
        int e0;
        int rel;
        bit v;
        int len;

        // Reset state, asserted with no clock edge yet.
        model_reset();
        rst_n = 1'b0;
        #1;
        check("reset_outputs", 32'({level, rise, fall, busy}), 32'h0);
        @(posedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b1;

        // Hold din low: nothing may happen.
        repeat (20) cycle(1'b0);
        settle();
        check("idle_rise_cnt", rise_cnt, 0);
        check("idle_fall_cnt", fall_cnt, 0);

        // Short high pulse (3 cycles) is rejected.
        r0 = rise_cnt;
        f0 = fall_cnt;
        repeat (3) cycle(1'b1);
        repeat (10) cycle(1'b0);
        settle();
        check("glitch_no_rise", rise_cnt - r0, 0);
        check("glitch_no_fall", fall_cnt - f0, 0);

        // Clean 0->1: rise five edges after s1 captures the new value.
        r0 = rise_cnt;
        e0 = edge_no + 1;
        repeat (10) cycle(1'b1);
        settle();
        check("rise_count", rise_cnt - r0, 1);
        check("rise_latency", last_rise_edge - e0, 5);
        check("level_after_rise", 32'(level), 32'h1);

        // Clean 1->0: single fall, no rise.
        r0 = rise_cnt;
        f0 = fall_cnt;
        e0 = edge_no + 1;
        repeat (10) cycle(1'b0);
        settle();
        check("fall_count", fall_cnt - f0, 1);
        check("fall_no_rise", rise_cnt - r0, 0);
        check("fall_latency", last_fall_edge - e0, 5);

        // Toggle every cycle for 10 cycles, ending high, then stay high.
        r0 = rise_cnt;
        e0 = edge_no + 10;
        for (int i = 0; i < 10; i++) cycle(i[0]);
        repeat (10) cycle(1'b1);
        settle();
        check("toggle_one_rise", rise_cnt - r0, 1);
        check("toggle_rise_latency", last_rise_edge - e0, 5);

        // Back to level 0 for the mid-qualification reset.
        repeat (10) cycle(1'b0);
        settle();

        // Reach WAIT with cnt=2, then assert reset between edges.
        repeat (4) cycle(1'b1);
        @(posedge clk);
        #2;
        check("busy_before_reset", 32'(busy), 32'h1);
        rst_n = 1'b0;
        #1;
        check("async_reset_outputs", 32'({level, rise, fall, busy}), 32'h0);
        @(posedge clk);
        @(posedge clk);
        #3;
        model_reset();
        rst_n = 1'b1;
        rel = edge_no;
        r0 = rise_cnt;
        repeat (10) cycle(1'b1);
        settle();
        check("rerise_count", rise_cnt - r0, 1);
        check("rerise_latency", last_rise_edge - rel, 6);

        // Randomized segments, including many sub-threshold glitches.
        for (int k = 0; k < 300; k++) begin
            v   = 1'($urandom_range(0, 1));
            len = int'($urandom_range(1, 7));
            repeat (len) cycle(v);
        end
        settle();
        check("queue_drained", 32'(expq.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
